booth_result_accum: RTL

- Downstream consumer of the radix-2 Booth multiplier.
- Watches the multiplier's done flag, captures each completed 2N-bit product exactly once, and sums BURST products into a wide signed accumulator.
- Presents the burst sum on a valid/ready output handshake.
- Detects dropped products (overrun) and accumulator overflow.

---
 rtl/booth_result_accum_if.sv | 31 +++
 rtl/booth_result_accum.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/booth_result_accum_if.sv
// Bus bundle between the Booth multiplier, the result accumulator and the
// downstream consumer of burst sums.
//   slave  : the accumulator (takes products, presents burst sums)
//   master : the environment (drives products, accepts burst sums)
interface booth_result_accum_if #(
   parameter int N     = 16,
   parameter int ACC_W = 40,
   parameter int BURST = 4
);
   localparam int CW = $clog2(BURST + 1);

   logic [2*N-1:0]   prod;
   logic             done;
   logic             clr;
   logic [ACC_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    cnt_o;
   logic             overrun;
   logic             ovf;

   modport slave (
      input  prod, done, clr, out_ready,
      output out_data, out_valid, cnt_o, overrun, ovf
   );

   modport master (
      output prod, done, clr, out_ready,
      input  out_data, out_valid, cnt_o, overrun, ovf
   );
endinterface

// File: rtl/booth_result_accum.sv
// Burst accumulator behind the radix-2 Booth multiplier.
// Captures one product per rising edge of the multiplier's done flag, sums
// BURST products into a signed ACC_W accumulator and presents the sum on a
// valid/ready handshake. Flags dropped products (overrun) and signed
// overflow (ovf); both are sticky until reset or clr.
//
// Build option: BOOTH_ACC_SAT_EN
//   undefined : accumulator wraps modulo 2^ACC_W, ovf still flags
//   defined   : accumulator saturates to the signed limits, ovf flags
//
// state  | meaning
// -------+-----------------------------------------------------------
// ACCUM  | collecting products, out_valid=0
// HOLD   | burst complete, out_data frozen, out_valid=1 until accepted
module booth_result_accum #(
   parameter int N     = 16,
   parameter int ACC_W = 40,
   parameter int BURST = 4
) (
   input  logic clk,
   input  logic reset,
   booth_result_accum_if.slave bus
);

   localparam int CW = $clog2(BURST + 1);

   localparam logic [0:0] S_ACCUM = 1'b0;
   localparam logic [0:0] S_HOLD  = 1'b1;

   localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]    CNT_BURST = CW'(BURST);
   localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

   logic             done_q;
   logic [ACC_W-1:0] acc_q,     acc_d;
   logic [CW-1:0]    cnt_q,     cnt_d;
   logic [0:0]       state_q,   state_d;
   logic             overrun_q, overrun_d;
   logic             ovf_q,     ovf_d;

   logic             cap;
   logic             handshake;
   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] sum_raw;
   logic             sum_ovf;
   logic [ACC_W-1:0] sum_res;

   // A held done level produces only one capture; done_q is the previous level.
   always_comb begin
      cap       = bus.done & ~done_q;
      handshake = (state_q == S_HOLD) & bus.out_ready;
   end

   // Sign-extended add with two's complement overflow detection and optional clamp.
   always_comb begin
      prod_ext = {{(ACC_W-2*N){bus.prod[2*N-1]}}, bus.prod};
      sum_raw  = acc_q + prod_ext;
      sum_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                 (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef BOOTH_ACC_SAT_EN
      if (sum_ovf) begin
         sum_res = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
      end else begin
         sum_res = sum_raw;
      end
`else
      sum_res = sum_raw;
`endif
   end

   // Next-state logic; priority is clr, then handshake, then capture.
   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      state_d   = state_q;
      overrun_d = overrun_q;
      ovf_d     = ovf_q;

      if (bus.clr) begin
         acc_d     = '0;
         cnt_d     = '0;
         state_d   = S_ACCUM;
         overrun_d = 1'b0;
         ovf_d     = 1'b0;
      end else if (state_q == S_HOLD) begin
         if (handshake) begin
            if (cap) begin
               // The new product starts the next burst; it cannot overflow
               // because ACC_W exceeds the product width.
               acc_d   = prod_ext;
               cnt_d   = CNT_ONE;
               state_d = (CNT_ONE == CNT_BURST) ? S_HOLD : S_ACCUM;
            end else begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_ACCUM;
            end
         end else if (cap) begin
            // Result still unconsumed: the product has nowhere to go.
            overrun_d = 1'b1;
         end
      end else begin
         if (cap) begin
            acc_d = sum_res;
            cnt_d = cnt_q + CNT_ONE;
            if (sum_ovf) begin
               ovf_d = 1'b1;
            end
            if ((cnt_q + CNT_ONE) == CNT_BURST) begin
               state_d = S_HOLD;
            end
         end
      end
   end

   // done_q tracks done every cycle, including while clr is asserted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q <= 1'b0;
      end else begin
         done_q <= bus.done;
      end
   end

   // Accumulator, burst counter, state and sticky flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         state_q   <= S_ACCUM;
         overrun_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         state_q   <= state_d;
         overrun_q <= overrun_d;
         ovf_q     <= ovf_d;
      end
   end

   // out_data is the accumulator itself; it is frozen while in HOLD.
   always_comb begin
      bus.out_data  = acc_q;
      bus.out_valid = (state_q == S_HOLD);
      bus.cnt_o     = cnt_q;
      bus.overrun   = overrun_q;
      bus.ovf       = ovf_q;
   end

endmodule
